// File: rtl/mmio_responder_if.sv
// Memory-stage request bus into the MMIO responder, with registered read data returned.
interface mmio_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byte_we;
    logic [31:0] req_wdata;
    logic [31:0] rdata;

    modport master (
        output req_valid, req_we, req_addr, req_byte_we, req_wdata,
        input  rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_byte_we, req_wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_responder.sv
// MMIO peripheral block: UART transmitter fed by a byte FIFO, a 64-bit cycle counter with
// a snapshotting high word, and a byte-writable scratch register.
module mmio_responder #(
    parameter int CLKS_PER_BIT        = 104,
    parameter int FIFO_DEPTH          = 8,
    parameter int MMIO_ADDR_START_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    mmio_responder_if.slave   bus,
    output logic              uart_tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t state;
    logic [CLK_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    logic [63:0] cycle_count;
    logic [31:0] cycle_hi_shadow;
    logic [31:0] scratch;
    logic [31:0] read_val;
    logic [31:0] count_ext;

    logic       accept;
    logic [2:0] word_off;
    logic       full;
    logic       empty;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       bit_done;
    logic       ov_clear;
    logic       addr_unused;

    assign accept      = clk_enable & bus.req_valid & bus.req_addr[MMIO_ADDR_START_BIT];
    assign word_off    = bus.req_addr[4:2];
    assign addr_unused = ^bus.req_addr;

    assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign empty    = (fifo_count == '0);
    assign push_req = accept & bus.req_we & (word_off == 3'd0) & bus.req_byte_we[0];
    assign push_ok  = push_req & ~full;
    assign bit_done = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
    // Popping at the end of STOP lets the next frame start without an idle cycle.
    assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
    assign ov_clear = accept & bus.req_we & (word_off == 3'd1)
                    & bus.req_byte_we[0] & bus.req_wdata[3];

    assign count_ext = 32'(fifo_count);

    always_comb begin
        read_val = 32'd0;
        case (word_off)
            3'd1: read_val = {24'd0, count_ext[3:0], overflow, (state != IDLE), empty, full};
            3'd2: read_val = cycle_count[31:0];
            3'd3: read_val = cycle_hi_shadow;
            3'd4: read_val = scratch;
            default: read_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.req_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            overflow        <= 1'b0;
            cycle_count     <= 64'd0;
            cycle_hi_shadow <= 32'd0;
            scratch         <= 32'd0;
            bus.rdata       <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // A dropped push in the same cycle as a clear leaves overflow set.
            if (push_req & full) begin
                overflow <= 1'b1;
            end else if (ov_clear) begin
                overflow <= 1'b0;
            end
            if (accept & bus.req_we & (word_off == 3'd4)) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.req_byte_we[i]) begin
                        scratch[8*i +: 8] <= bus.req_wdata[8*i +: 8];
                    end
                end
            end
            if (accept & ~bus.req_we & (word_off == 3'd2)) begin
                cycle_hi_shadow <= cycle_count[63:32];
            end
            if (accept) begin
                bus.rdata <= bus.req_we ? 32'd0 : read_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        state     <= START;
                        shift_reg <= fifo_mem[rd_ptr];
                        uart_tx   <= 1'b0;
                        clk_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        uart_tx <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            uart_tx   <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            state     <= START;
                            shift_reg <= fifo_mem[rd_ptr];
                            uart_tx   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: UART bit period in clk cycles; legal range 2 or more.
REQ-002 Parameter FIFO_DEPTH, default 8: TX FIFO entries; must be a power of two, 2 or more.
REQ-003 Parameter MMIO_ADDR_START_BIT, default 16: address bit that selects the MMIO region.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 clk_enable  input  1  pipeline advance; gates request acceptance and the rdata register only.
REQ-007 req_valid  input  1  memory-stage access present this cycle.
REQ-008 req_we  input  1  access is a store.
REQ-009 req_addr  input  32  byte address; byte offset taken from addr[1:0], word offset from addr[4:2].
REQ-010 req_byte_we  input  4  per-byte write enables, logical lanes already aligned, bit0 = byte 0.
REQ-011 req_wdata  input  32  store data, logical lanes already aligned.
REQ-012 rdata  output  32  registered read data, valid the cycle after acceptance.
REQ-013 uart_tx  output  1  serial 8N1 output, idle high.

Function
REQ-014 Access is accepted iff clk_enable & req_valid & req_addr[MMIO_ADDR_START_BIT].
REQ-015 Register map by word offset:
- 0 TX_DATA: write only.
- 1 STATUS: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky), bits[7:4] FIFO count.
- 2 CYCLE_LO.
- 3 CYCLE_HI.
- 4 SCRATCH: read/write.
- Offsets 5-7: read 0, writes ignored.
REQ-016 Read latency is exactly 1 cycle.
- rdata loads the selected register on an accepted read.
- rdata loads 0 on an accepted write.
- rdata holds its value when clk_enable = 0.
REQ-017 STATUS bits not listed in REQ-015 read 0.
- TX_DATA reads 0.
REQ-018 Accepted store to TX_DATA with req_byte_we[0] = 1 pushes req_wdata[7:0] into the FIFO.
REQ-019 A push while full is dropped and sets overflow.
- The full check uses the pre-cycle count, even if a pop occurs in the same cycle.
REQ-020 overflow clears on an accepted store to STATUS with req_byte_we[0] = 1 and req_wdata[3] = 1.
- If set and clear occur in the same cycle, set wins.
REQ-021 SCRATCH is written per byte lane where req_byte_we[i] = 1; other lanes are unchanged.
REQ-022 The 64-bit cycle counter increments every clk regardless of clk_enable.
- It wraps from 2^64-1 to 0.
- It is not writable.
REQ-023 Reading CYCLE_LO returns counter[31:0] and snapshots counter[63:32] into a shadow register in the same cycle.
- Reading CYCLE_HI returns the shadow, not the live value.
REQ-024 FIFO is circular, with pointer wrap at FIFO_DEPTH.
- Count ranges 0..FIFO_DEPTH; full when count = FIFO_DEPTH, empty when count = 0.
- Simultaneous push and pop when not full and not empty leaves count unchanged.
REQ-025 UART FSM states and transitions:
- IDLE -> START when the FIFO is not empty; pops one byte into the shift register in that cycle.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA shifts 8 bits LSB first, CLKS_PER_BIT cycles each, then -> STOP.
- STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-026 uart_tx value by state: 1 in IDLE, 0 in START, the current shift bit in DATA, 1 in STOP.
REQ-027 tx_busy = (state != IDLE).
REQ-028 Back-to-back bytes: the next START begins the cycle after STOP completes, giving exactly 10*CLKS_PER_BIT cycles per byte.
REQ-029 The UART runs independently of clk_enable.

Reset
REQ-030 While rst = 1 at a clock edge, the following SHALL hold on the next cycle:
- State = IDLE; uart_tx = 1.
- FIFO empty, pointers 0, overflow 0.
- Counter and shadow 0; SCRATCH 0; rdata 0.
- Requests in that cycle are ignored.
REQ-031 Reset mid-frame aborts transmission immediately, and uart_tx returns to 1 the next cycle.
- Queued bytes are discarded.

Verification
REQ-032 With CLKS_PER_BIT = 4, store 0x0000_00A5 to TX_DATA -> uart_tx shows:
- START low for 4 cycles;
- bits 1,0,1,0,0,1,0,1, each held for 4 cycles;
- STOP high for 4 cycles;
- STATUS then reads 0x02.
REQ-033 With the UART stalled (cannot drain) and FIFO_DEPTH = 8, push 9 bytes -> STATUS reads 0x8D (count 8, overflow, busy, full).
- Then store 0x8 to STATUS -> bit3 = 0.
REQ-034 Store 0x1122_3344 to SCRATCH with byte_we = 0xF, then 0xFFFF_FFFF with byte_we = 0x6 -> SCRATCH reads 0x11FF_FF44.
REQ-035 Drive the counter to 0x0000_0000_FFFF_FFFE, read CYCLE_LO, then read CYCLE_HI 5 cycles later -> CYCLE_HI returns 0x0000_0000 (the snapshot), not 0x1.
REQ-036 Hold clk_enable = 0 with req_valid = 1 and a TX_DATA store presented -> no push occurs and rdata is unchanged.
REQ-037 Assert rst during the DATA state -> uart_tx = 1 next cycle, STATUS reads 0x02, rdata = 0.
